alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, ALU settle cycles for MUL; legal 1..7.
REQ-002 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid_i, req1_valid_i  input  1  requester k has an op pending.
REQ-005 SHALL have ports req0_ready_o, req1_ready_o  output  1  requester k op accepted this cycle.
REQ-006 SHALL have ports req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i  input  32  operands.
REQ-007 SHALL have ports req0_ctr_i, req1_ctr_i  input  3  op code: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
REQ-008 SHALL have ports alu_src1_o, alu_src2_o  output  32  and alu_ctr_o  output  3  drive the shared ALU.
REQ-009 SHALL have port alu_res_i  input  32  shared ALU combinational result.
REQ-010 SHALL have ports rsp_valid_o  output  1, rsp_ready_i  input  1, rsp_id_o  output  1 (requester index), rsp_res_o  output  32, rsp_err_o  output  1.
REQ-011 SHALL have port busy_o  output  1  high in any state except IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-013 In IDLE, any valid: grant one requester, assert its ready_o combinationally that cycle, latch src1/src2/ctr/id, go EXEC; the other ready_o SHALL stay 0.
REQ-014 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; one valid -> grant it; pointer updates only on grant.
REQ-015 ready_o SHALL be 0 in EXEC and RESP; valid inputs then SHALL be held, not dropped.
REQ-016 alu_src1_o/alu_src2_o/alu_ctr_o SHALL drive latched registers, stable throughout EXEC.
REQ-017 EXEC SHALL last 1 cycle for non-MUL ops and MUL_LAT cycles for MUL, counted by a 3-bit down-counter.
REQ-018 On final EXEC cycle, alu_res_i SHALL be registered into rsp_res_o; next cycle state = RESP, rsp_valid_o = 1.
REQ-019 Accept-to-rsp_valid latency SHALL be 2 cycles (non-MUL) or MUL_LAT+1 cycles (MUL).
REQ-020 In RESP, rsp_res_o/rsp_id_o/rsp_err_o SHALL hold stable until rsp_ready_i = 1; that cycle completes the transfer and state -> IDLE.
REQ-021 No new grant SHALL occur in the RESP-exit cycle; minimum issue interval = 3 cycles.
REQ-022 Undefined control (X/unknown state) SHALL be unreachable; FSM default branch -> IDLE.

Reset
REQ-023 rst_i low SHALL immediately force state IDLE, counter 0, rr pointer favoring req0, rsp_valid_o 0, rsp_res_o 0, rsp_id_o 0, rsp_err_o 0, alu_*_o 0, busy_o 0, ready_o 0.
REQ-024 Reset mid-EXEC or mid-RESP SHALL abandon the op with no response produced.

Configuration
REQ-025 Macro ALU_SCHED_MUL_EN defined: MUL handled per REQ-017, rsp_err_o always 0.
REQ-026 ALU_SCHED_MUL_EN undefined: MUL accepted normally, EXEC 1 cycle, alu_ctr_o driven 000, rsp_res_o = 0, rsp_err_o = 1; other ops unchanged; MUL_LAT ignored.

Verification
REQ-027 Reset release, req0 ADD 5+7, rsp_ready_i=1 -> req0_ready_o pulses cycle 0, rsp_valid_o cycle 2, rsp_res_o=12, rsp_id_o=0, err 0.
REQ-028 Both valid every cycle, SUB ops -> grants alternate 0,1,0,1 starting with 0; each issue 3 cycles apart.
REQ-029 MUL_LAT=3, req1 MUL 0x10000 x 0x10000 -> alu_ctr_o=101 for 3 cycles, rsp_valid_o at cycle 4, rsp_res_o=0, id 1.
REQ-030 SRAI 0x80000000 by 4, rsp_ready_i held low 5 cycles -> rsp_res_o=0xF8000000 stable, rsp_valid_o high all 5 cycles, no new grant.
REQ-031 rst_i low during MUL EXEC cycle 2 -> all outputs zero same cycle; after release, next grant goes to req0.
REQ-032 Build without ALU_SCHED_MUL_EN, MUL 3x4 -> rsp_valid_o cycle 2, rsp_res_o=0, rsp_err_o=1.

Source files
------------

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin scheduler for one shared ALU
// Optional MUL support is enabled by defining ALU_SCHED_MUL_EN.
module alu_sched #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [2:0]  req0_ctr_i,
  input  logic [2:0]  req1_ctr_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [2:0]  alu_ctr_o,
  input  logic [31:0] alu_res_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_res_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

`ifdef ALU_SCHED_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif
  localparam logic [2:0] OpMul = 3'b101;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rr_q, rr_d;
  logic [31:0] src1_q, src1_d, src2_q, src2_d, res_q, res_d;
  logic [2:0]  ctr_q, ctr_d;
  logic        id_q, id_d;
  logic        mul_err_q, mul_err_d;
  logic        err_q, err_d;
  logic        grant0, grant1, gid;
  logic [2:0]  ctr_in;
  logic        is_mul;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    ctr_d     = ctr_q;
    id_d      = id_q;
    mul_err_d = mul_err_q;
    res_d     = res_q;
    err_d     = err_q;
    grant0    = 1'b0;
    grant1    = 1'b0;
    gid       = 1'b0;
    ctr_in    = 3'b000;
    is_mul    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          // rr_q remembers the last winner; a tie goes to the other requester
          gid       = (req0_valid_i && req1_valid_i) ? ~rr_q : req1_valid_i;
          grant0    = ~gid;
          grant1    = gid;
          ctr_in    = gid ? req1_ctr_i : req0_ctr_i;
          is_mul    = (ctr_in == OpMul);
          src1_d    = gid ? req1_src1_i : req0_src1_i;
          src2_d    = gid ? req1_src2_i : req0_src2_i;
          mul_err_d = is_mul && !MulEn;
          ctr_d     = (is_mul && !MulEn) ? 3'b000 : ctr_in;
          cnt_d     = (is_mul && MulEn) ? 3'(MUL_LAT - 1) : 3'd0;
          id_d      = gid;
          rr_d      = gid;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          res_d   = mul_err_q ? 32'd0 : alu_res_i;
          err_d   = mul_err_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      rr_q      <= 1'b1;
      src1_q    <= 32'd0;
      src2_q    <= 32'd0;
      ctr_q     <= 3'b000;
      id_q      <= 1'b0;
      mul_err_q <= 1'b0;
      res_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      ctr_q     <= ctr_d;
      id_q      <= id_d;
      mul_err_q <= mul_err_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  // ready is combinational, so it must also be masked while reset is held
  assign req0_ready_o = grant0 & rst_i;
  assign req1_ready_o = grant1 & rst_i;
  assign alu_src1_o   = src1_q;
  assign alu_src2_o   = src2_q;
  assign alu_ctr_o    = ctr_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_res_o    = res_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - self-checking bench for alu_sched with an ALU and scheduling reference model
// Follows the ALU_SCHED_MUL_EN build option of the design.
module tb_alu_sched;
  localparam int MUL_LAT = 3;
`ifdef ALU_SCHED_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] r0s1, r0s2, r1s1, r1s2;
  logic [2:0]  r0ctr, r1ctr;
  logic [31:0] alu_s1, alu_s2, alu_res;
  logic [2:0]  alu_ctr;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_res;
  int          checks = 0;
  int          failures = 0;
  int          last_grant;

  always #5 clk = ~clk;

  alu_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .req0_src1_i(r0s1), .req0_src2_i(r0s2), .req1_src1_i(r1s1), .req1_src2_i(r1s2),
    .req0_ctr_i(r0ctr), .req1_ctr_i(r1ctr),
    .alu_src1_o(alu_s1), .alu_src2_o(alu_s2), .alu_ctr_o(alu_ctr), .alu_res_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_res_o(rsp_res), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a ^ b;
      3'd2:    r = a << b[4:0];
      3'd3:    r = a + b;
      3'd4:    r = a - b;
      3'd5:    r = a * b;
      3'd6:    r = a + b;
      default: r = $signed(a) >>> b[4:0];
    endcase
    return r;
  endfunction

  always_comb alu_res = alu_fn(alu_ctr, alu_s1, alu_s2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int who, input bit both, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    int          g, lat;
    logic        exp_err;
    logic [31:0] exp_res;
    int          exp_lat;
    g       = both ? 1 - last_grant : who;
    exp_err = (op == 3'd5) && !MUL_EN;
    exp_res = exp_err ? 32'd0 : alu_fn(op, a, b);
    exp_lat = (op == 3'd5 && MUL_EN) ? MUL_LAT + 1 : 2;
    @(posedge clk); #1;
    r0s1 = a; r0s2 = b; r0ctr = op; r1s1 = a; r1s2 = b; r1ctr = op;
    req0_valid = both || who == 0;
    req1_valid = both || who == 1;
    rsp_ready  = (hold == 0);
    @(negedge clk);
    check("grant_ready", g ? req1_ready : req0_ready, 1);
    check("other_ready", g ? req0_ready : req1_ready, 0);
    last_grant = g;
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("alu_ctr", alu_ctr, exp_err ? 3'b000 : op);
        check("alu_src1", alu_s1, a);
        check("exec_busy", busy, 1);
      end
    end while (!rsp_valid && lat < 40);
    check("latency", lat, exp_lat);
    check("rsp_res", rsp_res, exp_res);
    check("rsp_id", rsp_id, g);
    check("rsp_err", rsp_err, exp_err);
    if (hold > 0) begin
      repeat (hold - 1) begin
        @(posedge clk); #1;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("hold_valid", rsp_valid, 1);
        check("hold_res", rsp_res, exp_res);
        check("hold_id", rsp_id, g);
        check("hold_no_grant", {req0_ready, req1_ready}, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      @(negedge clk);
      check("exit_valid", rsp_valid, 1);
      check("exit_no_grant", {req0_ready, req1_ready}, 0);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    end else begin
      @(posedge clk); #1;
      rsp_ready = 0;
    end
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", rsp_valid, 0);
  endtask

  initial begin
    int gc;
    int gtime[$];
    int gidq[$];
    rst_i = 0; req0_valid = 1; req1_valid = 1; rsp_ready = 0;
    r0s1 = 0; r0s2 = 0; r1s1 = 0; r1s2 = 0; r0ctr = 0; r1ctr = 0;
    last_grant = 1;
    repeat (2) @(negedge clk);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_res", rsp_res, 0);
    check("rst_id_err", {rsp_id, rsp_err}, 0);
    check("rst_alu", alu_s1 | alu_s2 | {29'd0, alu_ctr}, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; rst_i = 1;

    run_op(0, 0, 3'd3, 32'd5, 32'd7, 0);
    check("add_res_12", rsp_res, 32'd12);

    // round-robin from a fresh reset with both requesters always pending
    @(posedge clk); #1; rst_i = 0;
    @(posedge clk); #1; rst_i = 1; last_grant = 1;
    r0s1 = 10; r0s2 = 3; r0ctr = 3'd4; r1s1 = 100; r1s2 = 1; r1ctr = 3'd4;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gtime.push_back(c);
        gidq.push_back(req1_ready ? 1 : 0);
        check("rr_single", req0_ready & req1_ready, 0);
      end
      if (rsp_valid) check("rr_res", rsp_res, rsp_id ? 32'd99 : 32'd7);
    end
    gc = gtime.size();
    check("rr_count", gc, 5);
    for (int i = 0; i < gc && i < 5; i++) begin
      check("rr_id", gidq[i], i % 2);
      check("rr_time", gtime[i], 3 * i);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (6) @(posedge clk);
    #1 rsp_ready = 0;
    last_grant = 0;

    run_op(1, 0, 3'd5, 32'h10000, 32'h10000, 0);
    run_op(0, 0, 3'd7, 32'h8000_0000, 32'd4, 5);
    check("srai_res", rsp_res, 32'hF800_0000);
    run_op(0, 0, 3'd5, 32'd3, 32'd4, 0);
    run_op(1, 1, 3'd2, 32'h1, 32'd31, 1);

    for (int i = 0; i < 30; i++) begin
      run_op($urandom_range(0, 1), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
             $urandom, $urandom, $urandom_range(0, 2));
    end

    // reset during EXEC: op abandoned, pointer back to favouring req0
    run_op(0, 0, 3'd0, 32'hF0, 32'h3C, 0);
    @(posedge clk); #1;
    r0s1 = 32'h1234; r0s2 = 32'h5678; r0ctr = 3'd5; req0_valid = 1; rsp_ready = 1;
    @(negedge clk);
    check("pre_rst_grant", req0_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1;
    #2 rst_i = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_rsp", rsp_res | {30'd0, rsp_id, rsp_err}, 0);
    check("mid_rst_alu", alu_s1 | alu_s2 | {29'd0, alu_ctr}, 0);
    check("mid_rst_ready", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1; rst_i = 1;
    @(negedge clk);
    check("post_rst_valid", rsp_valid, 0);
    check("post_rst_req0", req0_ready, 1);
    check("post_rst_req1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (8) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
